// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity accumulator.
package serial_parity_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/parity_frame_counter.sv
// Bit-position counter for one frame; flags the accept that closes the frame.
module parity_frame_counter
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             last_in,
  output logic [CNT_W-1:0] cnt,
  output logic             close
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

  // in_last on the final position still produces a single close
  assign close = inc && (last_in || (cnt == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_parity_accumulator.sv
// XOR-folds a serial bit stream into one parity result per frame.
// Odd parity when SERIAL_PARITY_ODD_EN is defined, even parity otherwise.
module serial_parity_accumulator
  import serial_parity_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = cnt_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_len
);

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic PARITY_INV = 1'b1;
`else
  localparam logic PARITY_INV = 1'b0;
`endif

  state_t           state_q;
  state_t           state_d;
  logic             acc_q;
  logic [CNT_W-1:0] cnt;
  logic             inc;
  logic             close;

  // Handshake flags decode the state register only
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign inc       = in_valid && in_ready;

  parity_frame_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (inc),
    .clr     (close),
    .last_in (in_last),
    .cnt     (cnt),
    .close   (close)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close)     state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default:                state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 1'b0;
      out_parity <= 1'b0;
      out_len    <= '0;
    end else if (close) begin
      acc_q      <= 1'b0;
      out_parity <= acc_q ^ in_bit ^ PARITY_INV;
      out_len    <= cnt + CNT_W'(1);
    end else if (inc) begin
      acc_q      <= acc_q ^ in_bit;
    end
  end

endmodule

// File: tb/tb_serial_parity_accumulator.sv
// Scoreboard bench for serial_parity_accumulator (FRAME_LEN=8 and FRAME_LEN=1 instances).
module tb_serial_parity_accumulator;

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  typedef struct packed {
    logic       par;
    logic [3:0] len;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_bit, in_last, in_ready;
  logic       out_valid, out_ready, out_parity;
  logic [3:0] out_len;
  logic       in_valid1, in_bit1, in_last1, in_ready1;
  logic       out_valid1, out_ready1, out_parity1;
  logic [0:0] out_len1;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_parity_accumulator #(.FRAME_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_len(out_len)
  );

  serial_parity_accumulator #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_bit(in_bit1), .in_last(in_last1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_parity(out_parity1), .out_len(out_len1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_parity !== 1'b0 || out_len !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b ready=%b par=%b len=%0d expected 0 1 0 0",
               out_valid, in_ready, out_parity, out_len);
    end
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_len1: valid=%b ready=%b expected 0 1", out_valid1, in_ready1);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_full_frame();
    logic [7:0] pat;
    logic       p;
    pat = 8'b0100_1101;  // bit i is the i-th bit sent: 1,0,1,1,0,0,1,0
    p = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_bit = pat[i]; in_last = 1'b0;
      p = p ^ pat[i];
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_ready[%0d]: in_ready=%b expected 1", i, in_ready);
      end
      if (i == 7) sb.push_back('{par: p ^ INV, len: 4'd8});
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL full_latency: out_valid=%b queued=%0d expected 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_parity !== e.par) begin
        errors++;
        $display("FAIL full_parity: got %b expected %b", out_parity, e.par);
      end
      checks++;
      if (out_len !== e.len) begin
        errors++;
        $display("FAIL full_len: got %0d expected %0d", out_len, e.len);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_one_cycle: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_early_last();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; in_last = (i == 2);
      if (i == 2) sb.push_back('{par: 1'b1 ^ INV, len: 4'd3});
      tick();
    end
    // keep presenting a bit while the result is held; it must be ignored
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL last_ready: in_ready=%b expected 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL last_valid: out_valid=%b queued=%0d expected 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_parity !== e.par || out_len !== e.len) begin
        errors++;
        $display("FAIL last_result: par=%b len=%0d expected %b %0d", out_parity, out_len, e.par, e.len);
      end
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_ignored: out_valid=%b expected 0", out_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    logic       p;
    pat = 5'b11001;  // sent 1,0,0,1,1
    p = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = pat[i]; in_last = (i == 4);
      p = p ^ pat[i];
      if (i == 4) sb.push_back('{par: p ^ INV, len: 4'd5});
      tick();
    end
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sb.size() == 0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b expected 1 0", k, out_valid, in_ready);
      end else begin
        checks++;
        if (out_parity !== sb[0].par || out_len !== sb[0].len) begin
          errors++;
          $display("FAIL bp_stable[%0d]: par=%b len=%0d expected %b %0d",
                   k, out_parity, out_len, sb[0].par, sb[0].len);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL bp_accept: out_valid=%b queued=%0d expected 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_parity !== e.par || out_len !== e.len) begin
        errors++;
        $display("FAIL bp_result: par=%b len=%0d expected %b %0d", out_parity, out_len, e.par, e.len);
      end
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_accum: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0;
      if (i == 7) sb.push_back('{par: 1'b0 ^ INV, len: 4'd8});
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL rst_next_valid: out_valid=%b queued=%0d expected 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_parity !== e.par || out_len !== e.len) begin
        errors++;
        $display("FAIL rst_next_result: par=%b len=%0d expected %b %0d", out_parity, out_len, e.par, e.len);
      end
    end
    tick();
    // reset while a result is pending in HOLD
    out_ready = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_hold: out_valid=%b expected 1", out_valid);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_parity !== 1'b0 || out_len !== 4'd0) begin
      errors++;
      $display("FAIL rst_hold: valid=%b ready=%b par=%b len=%0d expected 0 1 0 0",
               out_valid, in_ready, out_parity, out_len);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
    sb.push_back('{par: 1'b1 ^ INV, len: 4'd1});
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL rst_clean_valid: out_valid=%b queued=%0d expected 1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_parity !== e.par || out_len !== e.len) begin
        errors++;
        $display("FAIL rst_clean_result: par=%b len=%0d expected %b %0d", out_parity, out_len, e.par, e.len);
      end
    end
    tick();
  endtask

  task automatic test_frame_len_one();
    logic [1:0] bits;
    bits = 2'b10;  // sent 0 then 1
    out_ready1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid1 = 1'b1; in_bit1 = bits[i]; in_last1 = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready1 !== 1'b1) begin
        errors++;
        $display("FAIL len1_ready[%0d]: in_ready=%b expected 1", i, in_ready1);
      end
      sb.push_back('{par: bits[i] ^ INV, len: 4'd1});
      tick();
      in_valid1 = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL len1_valid[%0d]: out_valid=%b queued=%0d expected 1", i, out_valid1, sb.size());
      end else begin
        e = sb.pop_front();
        checks++;
        if (out_parity1 !== e.par || {3'b000, out_len1} !== e.len) begin
          errors++;
          $display("FAIL len1_result[%0d]: par=%b len=%0d expected %b %0d",
                   i, out_parity1, out_len1, e.par, e.len);
        end
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL len1_gap[%0d]: out_valid=%b expected 0", i, out_valid1);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_bit1 = 1'b0; in_last1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_full_frame();
    test_early_last();
    test_backpressure();
    test_reset_mid_frame();
    test_frame_len_one();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
